// File: rtl/reg_wr_pkg.sv
// -----------------------------------------------------------------------------
// reg_wr_pkg
// Shared types and defaults for the register-write arbiter.
//   state_t    : arbiter FSM states (IDLE, SETUP, PULSE, HOLD)
//   *_CYC_DEF  : default phase lengths in clock cycles
//   cnt_width  : width of the single phase down-counter
// -----------------------------------------------------------------------------
package reg_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int SETUP_CYC_DEF = 1;
    localparam int PULSE_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF  = 4;

    // Counter must be able to hold the longest of the three phase lengths.
    function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int max_v;
        max_v = setup_cyc;
        max_v = (pulse_cyc > max_v) ? pulse_cyc : max_v;
        max_v = (hold_cyc  > max_v) ? hold_cyc  : max_v;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_wr_arbiter_if
// Requester handshake plus shared register write bus.
//   req/req_data : per-requester level request and flattened data
//   ack          : one-cycle one-hot completion pulse
//   busy         : a write transaction is in progress
//   wr_req       : write strobe, falling edge commits downstream
//   wr_data      : data to the register block
// Modports: master = arbiter side, slave = requesters / register block side.
// -----------------------------------------------------------------------------
interface reg_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic                      wr_req;
    logic [DATA_W-1:0]         wr_data;

    modport master (
        input  req,
        input  req_data,
        output ack,
        output busy,
        output wr_req,
        output wr_data
    );

    modport slave (
        output req,
        output req_data,
        input  ack,
        input  busy,
        input  wr_req,
        input  wr_data
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans req starting at ptr, wrapping,
// and reports the first set bit.
//   req          : request vector
//   ptr          : index to start scanning from
//   grant_onehot : one-hot winner (all zero when nothing requested)
//   grant_idx    : binary winner index
//   any          : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // Scan N candidates from ptr upward; the first requesting one wins.
    always_comb begin
        int               cand_s;
        logic [IDX_W-1:0] cand_idx_s;
        logic             hit_s;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand_s       = 0;
        cand_idx_s   = '0;
        hit_s        = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand_s     = int'(ptr) + i;
            cand_s     = (cand_s >= N) ? (cand_s - N) : cand_s;
            cand_idx_s = IDX_W'(cand_s);
            hit_s      = req[cand_idx_s] & ~any;
            any        = any | hit_s;
            grant_idx  = hit_s ? cand_idx_s : grant_idx;
            grant_onehot[cand_idx_s] = hit_s;
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wr_arbiter
// Shares the single write port of the configuration register block between
// NUM_REQ requesters. One winner per IDLE cycle; its data is latched and held
// through SETUP, a PULSE-long wr_req strobe and HOLD, so a 2-FF synchroniser
// downstream reliably sees the falling edge with stable data. ack pulses in
// the last HOLD cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reg_wr_arbiter_if.master (req, req_data, ack, busy, wr_req, wr_data)
// Optional feature macro: REG_WR_ARB_PRIO_EN
//   defined   -> requester 0 has fixed top priority and does not move rr_ptr
//   undefined -> pure round-robin
// -----------------------------------------------------------------------------
module reg_wr_arbiter
    import reg_wr_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    reg_wr_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [NUM_REQ-1:0] winner_oh_r;
    logic               wr_req_r;
    logic [DATA_W-1:0]  wr_data_r;
    logic [NUM_REQ-1:0] ack_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] arb_req_s;
    logic [NUM_REQ-1:0] rr_oh_s;
    logic [IDX_W-1:0]   rr_idx_s;
    logic               rr_any_s;
    logic [NUM_REQ-1:0] win_oh_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_any_s;
    logic               adv_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [DATA_W-1:0]  grant_data_s;

`ifdef REG_WR_ARB_PRIO_EN
    // Requester 0 is handled outside the round-robin ring.
    assign arb_req_s = bus.req & ~NUM_REQ'(1);
`else
    assign arb_req_s = bus.req;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req          (arb_req_s),
        .ptr          (rr_ptr_r),
        .grant_onehot (rr_oh_s),
        .grant_idx    (rr_idx_s),
        .any          (rr_any_s)
    );

    // Final winner selection, pointer advance and data mux of the winner.
    always_comb begin
        win_oh_s     = rr_oh_s;
        win_idx_s    = rr_idx_s;
        win_any_s    = rr_any_s;
        adv_s        = 1'b1;
`ifdef REG_WR_ARB_PRIO_EN
        if (bus.req[0]) begin
            win_oh_s  = NUM_REQ'(1);
            win_idx_s = '0;
            win_any_s = 1'b1;
            adv_s     = 1'b0;
        end else begin
            adv_s     = 1'b1;
        end
`endif
        next_ptr_s   = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : (win_idx_s + IDX_W'(1));
        grant_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_data_s = win_oh_s[i] ? bus.req_data[i*DATA_W +: DATA_W] : grant_data_s;
        end
    end

    // Transaction FSM: grant, setup, strobe, hold, ack; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rr_ptr_r    <= '0;
            winner_oh_r <= '0;
            wr_req_r    <= 1'b0;
            wr_data_r   <= '0;
            ack_r       <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= '0;
                    if (win_any_s) begin
                        wr_data_r   <= grant_data_s;
                        winner_oh_r <= win_oh_s;
                        if (adv_s) begin
                            rr_ptr_r <= next_ptr_s;
                        end
                        cnt_r   <= CNT_W'(SETUP_CYC);
                        busy_r  <= 1'b1;
                        state_r <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_r == CNT_W'(1)) begin
                        cnt_r    <= CNT_W'(PULSE_CYC);
                        wr_req_r <= 1'b1;
                        state_r  <= PULSE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_r == CNT_W'(1)) begin
                        cnt_r    <= CNT_W'(HOLD_CYC);
                        wr_req_r <= 1'b0;
                        state_r  <= HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Registered ack must be raised one cycle early to land in the last HOLD cycle.
                    ack_r <= (cnt_r == CNT_W'(2)) ? winner_oh_r : '0;
                    if (cnt_r == CNT_W'(1)) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    wr_req_r <= 1'b0;
                    ack_r    <= '0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_req  = wr_req_r;
    assign bus.wr_data = wr_data_r;
    assign bus.ack     = ack_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_wr_arbiter
// Directed scenarios push expected transactions (requester, data, grant cycle)
// into a queue; a monitor derives busy/wr_req/wr_data/ack expectations from the
// queue head every cycle and checks the committed value of a model register
// block (2-FF synchroniser + falling-edge detect) at ack time.
// -----------------------------------------------------------------------------
module tb_reg_wr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int S       = 1;
    localparam int P       = 4;
    localparam int H       = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         g;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic       sync1_r, sync2_r, sync3_r;
    logic [7:0] dout_r;

    reg_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    reg_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register block model: commits wr_data on the synchronised falling edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            dout_r  <= 8'h00;
        end else begin
            sync1_r <= bus.wr_req;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            if (sync3_r && !sync2_r) dout_r <= bus.wr_data;
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, got, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input int idx, input logic [7:0] data, input int g);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.g    = g;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    initial begin : monitor
        int   k;
        int   e_busy;
        int   e_wr;
        int   e_ack;
        logic last;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("rst_wr_req", int'(bus.wr_req), 0);
                chk("rst_wr_data", int'(bus.wr_data), 0);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_ack", int'(bus.ack), 0);
                exp_q.delete();
            end else begin
                e_busy = 0;
                e_wr   = 0;
                e_ack  = 0;
                last   = 1'b0;
                if (exp_q.size() > 0 && cyc > exp_q[0].g) begin
                    k      = cyc - exp_q[0].g;
                    e_busy = 1;
                    e_wr   = (k >= S + 1 && k <= S + P) ? 1 : 0;
                    chk("wr_data", int'(bus.wr_data), int'(exp_q[0].data));
                    if (k == S + P + H) begin
                        e_ack = 1 << exp_q[0].idx;
                        chk("commit_dout", int'(dout_r), int'(exp_q[0].data));
                        last = 1'b1;
                    end
                end
                chk("busy", int'(bus.busy), e_busy);
                chk("wr_req", int'(bus.wr_req), e_wr);
                chk("ack", int'(bus.ack), e_ack);
                if (last) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        wait_cyc(3);
        rst = 1'b0;

        // Single write from requester 1.
        wait_cyc(5);
        bus.req_data[15:8] = 8'hA5;
        bus.req[1]         = 1'b1;
        push(1, 8'hA5, 5);
        wait_cyc(14);
        bus.req = '0;

        // Contention: both requesters held for four transactions.
        wait_cyc(17);
        bus.req_data = 16'h2211;
        bus.req      = 2'b11;
`ifdef REG_WR_ARB_PRIO_EN
        push(0, 8'h11, 17);
        push(0, 8'h11, 27);
        push(0, 8'h11, 37);
        push(0, 8'h11, 47);
`else
        push(0, 8'h11, 17);
        push(1, 8'h22, 27);
        push(0, 8'h11, 37);
        push(1, 8'h22, 47);
`endif
        wait_cyc(56);
        bus.req = '0;

        // Data change after grant must be ignored.
        wait_cyc(59);
        bus.req_data[7:0] = 8'h3C;
        bus.req[0]        = 1'b1;
        push(0, 8'h3C, 59);
        wait_cyc(62);
        bus.req_data[7:0] = 8'hFF;
        wait_cyc(68);
        bus.req = '0;

        // Requester 1 pulses while busy: no grant, no ack for it.
        wait_cyc(71);
        bus.req_data[7:0] = 8'h5A;
        bus.req[0]        = 1'b1;
        push(0, 8'h5A, 71);
        wait_cyc(74);
        bus.req_data[15:8] = 8'h77;
        bus.req[1]         = 1'b1;
        wait_cyc(75);
        bus.req[1] = 1'b0;
        wait_cyc(80);
        bus.req = '0;

        // Reset in the middle of the strobe, then a normal write.
        wait_cyc(83);
        bus.req_data[7:0] = 8'h99;
        bus.req[0]        = 1'b1;
        push(0, 8'h99, 83);
        wait_cyc(86);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        bus.req = '0;
        wait_cyc(89);
        rst = 1'b0;
        wait_cyc(91);
        bus.req_data[7:0] = 8'h42;
        bus.req[0]        = 1'b1;
        push(0, 8'h42, 91);
        wait_cyc(100);
        bus.req = '0;

        wait_cyc(105);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
